data_frame_parser: RTL

Consumer end of the MinimumTrigger read-out interface, in the RD_CLK domain. Accepts the 64-bit frame stream (DOUT/oVALID, back-pressured through iREADY) and validates the frame structure (header, header-2, data words, footer). Extracts channel ID, 48-bit timestamp, baseline and threshold, and forwards the 64-bit sample words downstream with a registered valid/ready handshake. Reports per-frame errors and keeps saturating frame/error counters for a later AXI-Lite status block.

---
 rtl/frame_fmt_pkg.sv | 46 ++++
 rtl/data_frame_parser_if.sv | 26 ++
 rtl/frame_out_reg.sv | 45 ++++
 rtl/data_frame_parser.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/frame_fmt_pkg.sv
// rtl/frame_fmt_pkg.sv - frame format constants, field positions and parser state codes
// Purpose: the frame layout shared by the trigger frame generator and the parser.
// Contents: header/footer tags, bit positions of every header field, state codes,
//           error vector type and the header length range check.
package frame_fmt_pkg;

    localparam logic [7:0] HEADER_ID = 8'hAA;
    localparam logic [7:0] FOOTER_ID = 8'h55;

    // Header-1 / footer
    localparam int ID_MSB   = 63;
    localparam int ID_LSB   = 56;
    localparam int CH_MSB   = 55;
    localparam int CH_LSB   = 48;
    localparam int LEN_MSB  = 47;
    localparam int LEN_LSB  = 36;
    localparam int TSL_MSB  = 31;
    localparam int TSL_LSB  = 0;

    // Header-2
    localparam int TSH_MSB  = 63;
    localparam int TSH_LSB  = 48;
    localparam int BASE_MSB = 47;
    localparam int BASE_LSB = 36;
    localparam int THR_MSB  = 35;
    localparam int THR_LSB  = 23;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE = 3'd0;
    localparam state_t ST_HDR2 = 3'd1;
    localparam state_t ST_DATA = 3'd2;
    localparam state_t ST_FTR  = 3'd3;
    localparam state_t ST_DROP = 3'd4;

    typedef struct packed {
        logic footer_bad;
        logic len_bad;
        logic hdr_bad;
    } err_t;

    function automatic logic len_ok(input logic [11:0] len, input int max_len);
        return (len != 12'd0) && (len <= 12'(max_len));
    endfunction

endpackage

// File: rtl/data_frame_parser_if.sv
// rtl/data_frame_parser_if.sv - frame input and sample output stream bundle
// Purpose: groups the trigger-side word stream (DIN/DIN_VALID/DIN_READY) and the
//          downstream sample stream (SAMPLE_DATA/VALID/READY/LAST).
// Modports: slave  - the parser (consumes DIN, produces SAMPLE_*)
//           master - the environment (produces DIN, consumes SAMPLE_*)
interface data_frame_parser_if #(
    parameter int DIN_WIDTH = 64
);
    logic [DIN_WIDTH-1:0] DIN;
    logic                 DIN_VALID;
    logic                 DIN_READY;
    logic [DIN_WIDTH-1:0] SAMPLE_DATA;
    logic                 SAMPLE_VALID;
    logic                 SAMPLE_READY;
    logic                 SAMPLE_LAST;

    modport master (
        output DIN, DIN_VALID, SAMPLE_READY,
        input  DIN_READY, SAMPLE_DATA, SAMPLE_VALID, SAMPLE_LAST
    );

    modport slave (
        input  DIN, DIN_VALID, SAMPLE_READY,
        output DIN_READY, SAMPLE_DATA, SAMPLE_VALID, SAMPLE_LAST
    );
endinterface

// File: rtl/frame_out_reg.sv
// rtl/frame_out_reg.sv - one-deep registered valid/ready output stage with last flag
// Purpose: holds one data word for the downstream consumer; a new word may be
//          loaded in the same cycle the held one is taken (full throughput).
// Ports: clk_i, rst_i (sync, active high), load_i/data_i/last_i (new word),
//        ready_i (downstream ready), data_o/valid_o/last_o (registered outputs),
//        can_load_o (register is empty or being drained this cycle).
module frame_out_reg #(
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  load_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  last_i,
    input  logic                  ready_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  valid_o,
    output logic                  last_o,
    output logic                  can_load_o
);
    logic [DATA_WIDTH-1:0] data_q;
    logic                  valid_q;
    logic                  last_q;

    assign can_load_o = ~valid_q | ready_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else if (load_i) begin
            data_q  <= data_i;
            valid_q <= 1'b1;
            last_q  <= last_i;
        end else if (ready_i) begin
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;
    assign last_o  = last_q;
endmodule

// File: rtl/data_frame_parser.sv
// rtl/data_frame_parser.sv - MinimumTrigger read-out frame parser (RD_CLK domain)
// Purpose: validates header-1 / header-2 / data / footer framing, extracts header
//          fields, forwards data words through a registered valid/ready stage and
//          reports per-frame errors with saturating good/error frame counters.
// Ports: RD_CLK, RD_RESET (sync, active high); bus (slave): DIN/DIN_VALID/DIN_READY in,
//        SAMPLE_DATA/VALID/READY/LAST out; HDR_VALID + CHANNEL_ID, TIMESTAMP, FRAME_LEN,
//        BASELINE, THRESHOLD header fields; FRAME_DONE; ERR {footer_bad,len_bad,hdr_bad};
//        FRAME_CNT, ERR_CNT.
module data_frame_parser
    import frame_fmt_pkg::*;
#(
    parameter int DIN_WIDTH              = 64,
    parameter int ADC_RESOLUTION_WIDTH   = 12,
    parameter int TIME_STAMP_WIDTH       = 48,
    parameter int FIRST_TIME_STAMP_WIDTH = 32,
    parameter int MAX_FRAME_LENGTH       = 50,
    parameter int CNT_WIDTH              = 16
) (
    input  logic                            RD_CLK,
    input  logic                            RD_RESET,
    data_frame_parser_if.slave              bus,
    output logic                            HDR_VALID,
    output logic [7:0]                      CHANNEL_ID,
    output logic [TIME_STAMP_WIDTH-1:0]     TIMESTAMP,
    output logic [11:0]                     FRAME_LEN,
    output logic [ADC_RESOLUTION_WIDTH-1:0] BASELINE,
    output logic [ADC_RESOLUTION_WIDTH:0]   THRESHOLD,
    output logic                            FRAME_DONE,
    output logic [2:0]                      ERR,
    output logic [CNT_WIDTH-1:0]            FRAME_CNT,
    output logic [CNT_WIDTH-1:0]            ERR_CNT
);
    logic [DIN_WIDTH-1:0] word;

    // Frame-in-progress context, latched from header-1
    state_t                            state_q, state_d;
    logic [7:0]                        hch_q, hch_d;
    logic [11:0]                       hlen_q, hlen_d;
    logic [FIRST_TIME_STAMP_WIDTH-1:0] htsl_q, htsl_d;
    logic [11:0]                       cnt_q, cnt_d;
    logic                              bad_run_q, bad_run_d;

    // Published header fields; only change together with HDR_VALID
    logic                              hdr_valid_q, hdr_valid_d;
    logic [7:0]                        chan_q, chan_d;
    logic [TIME_STAMP_WIDTH-1:0]       ts_q, ts_d;
    logic [11:0]                       flen_q, flen_d;
    logic [ADC_RESOLUTION_WIDTH-1:0]   base_q, base_d;
    logic [ADC_RESOLUTION_WIDTH:0]     thr_q, thr_d;
    logic                              done_q, done_d;
    err_t                              err_q, err_d;
    logic [CNT_WIDTH-1:0]              fcnt_q, fcnt_d;
    logic [CNT_WIDTH-1:0]              ecnt_q, ecnt_d;
    logic [CNT_WIDTH+1:0]              ecnt_sum;

    logic can_load;
    logic accept;
    logic load;
    logic last_word;
    logic is_hdr;
    logic is_ftr_ok;
    logic take_hdr;

    assign word      = bus.DIN;
    assign is_hdr    = (word[ID_MSB:ID_LSB] == HEADER_ID);
    assign is_ftr_ok = (word[ID_MSB:ID_LSB] == FOOTER_ID) && (word[CH_MSB:CH_LSB] == hch_q);

    // Ready is held low during reset so nothing is consumed while the parser is cleared.
    assign bus.DIN_READY = ~RD_RESET & ((state_q == ST_DATA) ? can_load : 1'b1);
    assign accept        = bus.DIN_VALID & bus.DIN_READY;
    assign load          = accept & (state_q == ST_DATA);
    assign last_word     = (cnt_q == hlen_q - 12'd1);

    frame_out_reg #(
        .DATA_WIDTH (DIN_WIDTH)
    ) u_out (
        .clk_i      (RD_CLK),
        .rst_i      (RD_RESET),
        .load_i     (load),
        .data_i     (word),
        .last_i     (last_word),
        .ready_i    (bus.SAMPLE_READY),
        .data_o     (bus.SAMPLE_DATA),
        .valid_o    (bus.SAMPLE_VALID),
        .last_o     (bus.SAMPLE_LAST),
        .can_load_o (can_load)
    );

    always_comb begin
        state_d     = state_q;
        hch_d       = hch_q;
        hlen_d      = hlen_q;
        htsl_d      = htsl_q;
        cnt_d       = cnt_q;
        bad_run_d   = bad_run_q;
        hdr_valid_d = 1'b0;
        chan_d      = chan_q;
        ts_d        = ts_q;
        flen_d      = flen_q;
        base_d      = base_q;
        thr_d       = thr_q;
        done_d      = 1'b0;
        err_d       = '0;
        take_hdr    = 1'b0;

        if (accept) begin
            case (state_q)
                ST_IDLE: begin
                    if (is_hdr) begin
                        take_hdr = 1'b1;
                    end else if (!bad_run_q) begin
                        // Report a run of garbage once, not per word.
                        err_d.hdr_bad = 1'b1;
                        bad_run_d     = 1'b1;
                    end
                end
                ST_DROP: begin
                    take_hdr = is_hdr;
                end
                ST_HDR2: begin
                    hdr_valid_d = 1'b1;
                    chan_d      = hch_q;
                    flen_d      = hlen_q;
                    ts_d        = {word[TSH_MSB:TSH_LSB], htsl_q};
                    base_d      = word[BASE_MSB:BASE_LSB];
                    thr_d       = word[THR_MSB:THR_LSB];
                    cnt_d       = 12'd0;
                    state_d     = ST_DATA;
                end
                ST_DATA: begin
                    cnt_d = cnt_q + 12'd1;
                    if (last_word) begin
                        state_d = ST_FTR;
                    end
                end
                ST_FTR: begin
                    state_d = ST_IDLE;
                    if (is_ftr_ok) begin
                        done_d = 1'b1;
                    end else begin
                        err_d.footer_bad = 1'b1;
                        // A header arriving where the footer should be starts the next frame.
                        take_hdr = is_hdr;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        if (take_hdr) begin
            bad_run_d = 1'b0;
            if (len_ok(word[LEN_MSB:LEN_LSB], MAX_FRAME_LENGTH)) begin
                state_d = ST_HDR2;
                hch_d   = word[CH_MSB:CH_LSB];
                hlen_d  = word[LEN_MSB:LEN_LSB];
                htsl_d  = word[TSL_MSB:TSL_LSB];
            end else begin
                err_d.len_bad = 1'b1;
                state_d       = ST_DROP;
            end
        end

        fcnt_d = (done_d && !(&fcnt_q)) ? fcnt_q + 1'b1 : fcnt_q;

        // A bad footer that is also a bad header counts as two errored frames.
        ecnt_sum = {2'b00, ecnt_q} + (CNT_WIDTH+2)'(err_d.footer_bad)
                                   + (CNT_WIDTH+2)'(err_d.len_bad);
        ecnt_d   = (ecnt_sum > {2'b00, {CNT_WIDTH{1'b1}}}) ? '1 : ecnt_sum[CNT_WIDTH-1:0];
    end

    always_ff @(posedge RD_CLK) begin
        if (RD_RESET) begin
            state_q     <= ST_IDLE;
            hch_q       <= '0;
            hlen_q      <= '0;
            htsl_q      <= '0;
            cnt_q       <= '0;
            bad_run_q   <= 1'b0;
            hdr_valid_q <= 1'b0;
            chan_q      <= '0;
            ts_q        <= '0;
            flen_q      <= '0;
            base_q      <= '0;
            thr_q       <= '0;
            done_q      <= 1'b0;
            err_q       <= '0;
            fcnt_q      <= '0;
            ecnt_q      <= '0;
        end else begin
            state_q     <= state_d;
            hch_q       <= hch_d;
            hlen_q      <= hlen_d;
            htsl_q      <= htsl_d;
            cnt_q       <= cnt_d;
            bad_run_q   <= bad_run_d;
            hdr_valid_q <= hdr_valid_d;
            chan_q      <= chan_d;
            ts_q        <= ts_d;
            flen_q      <= flen_d;
            base_q      <= base_d;
            thr_q       <= thr_d;
            done_q      <= done_d;
            err_q       <= err_d;
            fcnt_q      <= fcnt_d;
            ecnt_q      <= ecnt_d;
        end
    end

    assign HDR_VALID  = hdr_valid_q;
    assign CHANNEL_ID = chan_q;
    assign TIMESTAMP  = ts_q;
    assign FRAME_LEN  = flen_q;
    assign BASELINE   = base_q;
    assign THRESHOLD  = thr_q;
    assign FRAME_DONE = done_q;
    assign ERR        = err_q;
    assign FRAME_CNT  = fcnt_q;
    assign ERR_CNT    = ecnt_q;
endmodule
